// File: rtl/gb_frame_scaler.sv
// Pixel source for the 1280x1024 VGA timing stage. Maps scan coordinates onto a
// double-banked 160x144 Game Boy frame buffer, upscales by SCALE, palettes the
// 2-bit shades and drives the 12-bit colour bus. It also owns the bank swap handshake.
// Latency: coordinate -> pixel_color is LEAD (3) cycles. The fetch runs LEAD columns
// ahead, so pixel_color while X_pix = n is the colour of screen column n.
// Backpressure: none. The timing stage free-runs and every stage advances each cycle.
// Ports:
//   pixel_clk, rst              : sole clock, async active-high reset
//   X_pix, Y_pix, H/V_visible   : scan position and active flags from the timing stage
//   fb_addr, fb_rd_en, fb_data  : synchronous frame RAM read port (data one cycle after address)
//   fb_swap_req/ack, fb_bank    : bank swap handshake with the LCD capture side
//   pixel_color                 : {B,G,R} colour for the current coordinate
module gb_frame_scaler #(
  parameter int          SCALE    = 6,
  parameter int          H_OFFSET = 160,
  parameter int          V_OFFSET = 80,
  parameter int          LEAD     = 3,
  parameter logic [11:0] PAL0     = 12'hBF9,
  parameter logic [11:0] PAL1     = 12'h7A5,
  parameter logic [11:0] PAL2     = 12'h353,
  parameter logic [11:0] PAL3     = 12'h120,
  parameter logic [11:0] BORDER   = 12'h000
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [10:0] X_pix,
  input  logic [10:0] Y_pix,
  input  logic        H_visible,
  input  logic        V_visible,
  output logic [15:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [1:0]  fb_data,
  input  logic        fb_swap_req,
  output logic        fb_swap_ack,
  output logic        fb_bank,
  output logic [11:0] pixel_color
);

  localparam int GB_W = 160;
  localparam int GB_H = 144;
  localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [10:0]   X_LO     = 11'(H_OFFSET);
  localparam logic [10:0]   X_HI     = 11'(H_OFFSET + GB_W * SCALE);
  localparam logic [10:0]   Y_LO     = 11'(V_OFFSET);
  localparam logic [10:0]   Y_HI     = 11'(V_OFFSET + GB_H * SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  logic [10:0]   xe, y_prev;
  logic          h_prev, v_prev, synced, pending;
  logic [SW-1:0] hs, hs_cur, vs;
  logic [7:0]    gc, gc_cur, gr;
  logic [14:0]   rowbase;
  logic          vis, in_win, x_start, h_fall, y_prev_in, v_fall, swap_now;
  logic          vis_p1, win_p2, vis_p2;

  // The fetch runs LEAD columns ahead of the scan position to hide the pipeline.
  assign xe = X_pix + 11'(LEAD);

  always_comb begin
    vis       = H_visible & V_visible;
    // synced stays low after a reset until a vertical blank has been seen.
    // This keeps a partial frame with stale row counters off the screen.
    in_win    = vis & synced & (xe >= X_LO) & (xe < X_HI) & (Y_pix >= Y_LO) & (Y_pix < Y_HI);
    x_start   = (xe == X_LO);
    // Counters restart at the first image column. The override makes column 0
    // usable in the same cycle as the restart.
    hs_cur    = x_start ? '0 : hs;
    gc_cur    = x_start ? '0 : gc;
    h_fall    = h_prev & ~H_visible;
    y_prev_in = (y_prev >= Y_LO) & (y_prev < Y_HI);
    v_fall    = v_prev & ~V_visible;
    // A request landing on the blanking edge itself joins this swap.
    swap_now  = v_fall & (pending | fb_swap_req);
  end

  // Edge detectors and the row of the line that just ended.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_prev <= 1'b0;
      v_prev <= 1'b0;
      y_prev <= '0;
      synced <= 1'b0;
    end else begin
      h_prev <= H_visible;
      v_prev <= V_visible;
      y_prev <= Y_pix;
      synced <= synced | ~V_visible;
    end
  end

  // Horizontal: hs counts SCALE screen columns per source column gc.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hs <= '0;
      gc <= '0;
    end else if (in_win) begin
      if (hs_cur == SUB_LAST) begin
        hs <= '0;
        gc <= (gc_cur == 8'(GB_W - 1)) ? gc_cur : gc_cur + 8'd1;
      end else begin
        hs <= hs_cur + SW'(1);
        gc <= gc_cur;
      end
    end
  end

  // Vertical: advance once per image line, at the end of the line. The row base
  // tracks gr*160 by repeated addition.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vs      <= '0;
      gr      <= '0;
      rowbase <= '0;
    end else if (!V_visible) begin
      vs      <= '0;
      gr      <= '0;
      rowbase <= '0;
    end else if (h_fall && y_prev_in) begin
      if (vs == SUB_LAST) begin
        vs <= '0;
        if (gr != 8'(GB_H - 1)) begin
          gr      <= gr + 8'd1;
          rowbase <= rowbase + 15'(GB_W);
        end
      end else begin
        vs <= vs + SW'(1);
      end
    end
  end

  function automatic logic [11:0] shade(input logic [1:0] s);
    case (s)
      2'd0:    shade = PAL0;
      2'd1:    shade = PAL1;
      2'd2:    shade = PAL2;
      default: shade = PAL3;
    endcase
  endfunction

  // Stage 0 issues the RAM read. Stage 1 is the RAM. Stage 2 applies the palette.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      fb_addr     <= '0;
      fb_rd_en    <= 1'b0;
      vis_p1      <= 1'b0;
      win_p2      <= 1'b0;
      vis_p2      <= 1'b0;
      pixel_color <= 12'h000;
    end else begin
      fb_rd_en <= in_win;
      if (in_win) begin
        fb_addr <= {fb_bank, rowbase + 15'(gc_cur)};
      end
      vis_p1 <= vis;
      win_p2 <= fb_rd_en;
      vis_p2 <= vis_p1;
      if (win_p2) begin
        pixel_color <= shade(fb_data);
      end else if (vis_p2) begin
        pixel_color <= BORDER;
      end else begin
        pixel_color <= 12'h000;
      end
    end
  end

  // Bank swap happens only at the start of vertical blank. Pending requests
  // collapse into a single swap.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      fb_swap_ack <= 1'b0;
      fb_bank     <= 1'b0;
    end else begin
      fb_swap_ack <= swap_now;
      fb_bank     <= fb_bank ^ swap_now;
      pending     <= swap_now ? 1'b0 : (pending | fb_swap_req);
    end
  end

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Bench for gb_frame_scaler: drives compressed scan timing and models the frame RAM.
// The per-cycle reference computes image column and row by division from the coordinates.
// A vector table checks the scan-line boundaries.
module tb_gb_frame_scaler;
  localparam logic [11:0] PAL0 = 12'hBF9, PAL1 = 12'h7A5, PAL2 = 12'h353, PAL3 = 12'h120;
  localparam logic [11:0] BORDER = 12'h000;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [10:0] X_pix, Y_pix;
  logic        H_visible, V_visible;
  logic [15:0] fb_addr;
  logic        fb_rd_en;
  logic [1:0]  fb_data = 2'd0;
  logic        fb_swap_req, fb_swap_ack, fb_bank;
  logic [11:0] pixel_color;

  always #5 pixel_clk = ~pixel_clk;

  gb_frame_scaler dut (
    .pixel_clk(pixel_clk), .rst(rst), .X_pix(X_pix), .Y_pix(Y_pix),
    .H_visible(H_visible), .V_visible(V_visible), .fb_addr(fb_addr),
    .fb_rd_en(fb_rd_en), .fb_data(fb_data), .fb_swap_req(fb_swap_req),
    .fb_swap_ack(fb_swap_ack), .fb_bank(fb_bank), .pixel_color(pixel_color)
  );

  // Synchronous frame RAM: data is valid the cycle after the address.
  logic [1:0] mem [0:65535];
  always @(posedge pixel_clk) if (fb_rd_en) fb_data <= mem[fb_addr];

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] shade(input logic [1:0] s);
    case (s)
      2'd0: return PAL0;
      2'd1: return PAL1;
      2'd2: return PAL2;
      default: return PAL3;
    endcase
  endfunction

  function automatic int slot_of(input int y);
    case (y)
      79: return 0; 80: return 1; 85: return 2; 86: return 3; 943: return 4; 944: return 5;
      default: return -1;
    endcase
  endfunction

  // Reference model: one record per cycle, with the window decision and the
  // source pixel index derived straight from the screen geometry.
  typedef struct { bit win; int idx; bit bank; } smp_t;
  smp_t h1, h2, h3;
  bit   fv, vprev_r, vprev_f, bankm, pend, exp_ack, cap_en = 1'b0;
  int   ack_cnt = 0;
  logic [11:0] cap_col  [0:5][0:1279];
  logic        cap_rd   [0:5][0:1279];
  logic [15:0] cap_addr [0:5][0:1279];

  always @(negedge pixel_clk) begin : model
    smp_t cur;
    int   xe, y, s;
    bit   take;
    if (rst) begin
      check("rst_color", int'(pixel_color), 0);
      check("rst_rd_en", int'(fb_rd_en), 0);
      check("rst_addr", int'(fb_addr), 0);
      check("rst_ack", int'(fb_swap_ack), 0);
      check("rst_bank", int'(fb_bank), 0);
      h1 = '{0, 0, 0}; h2 = '{0, 0, 0}; h3 = '{0, 0, 0};
      fv = 0; vprev_r = 1; vprev_f = 0; bankm = 0; pend = 0; exp_ack = 0;
    end else begin
      check("pixel_color", int'(pixel_color),
            h3.win ? int'(shade(mem[int'(h3.bank) * 32768 + h3.idx])) : int'(BORDER));
      check("fb_rd_en", int'(fb_rd_en), int'(h1.win));
      if (h1.win) check("fb_addr", int'(fb_addr), int'(h1.bank) * 32768 + h1.idx);
      check("fb_bank", int'(fb_bank), int'(bankm));
      check("fb_swap_ack", int'(fb_swap_ack), int'(exp_ack));
      if (fb_swap_ack) ack_cnt++;
      if (cap_en && H_visible && V_visible) begin
        s = slot_of(int'(Y_pix));
        if (s >= 0) begin
          cap_col[s][X_pix]  = pixel_color;
          cap_rd[s][X_pix]   = fb_rd_en;
          cap_addr[s][X_pix] = fb_addr;
        end
      end
      // An image is shown only once a frame has started cleanly.
      if (V_visible && !vprev_r) fv = 1;
      xe = int'(X_pix) + 3;
      y  = int'(Y_pix);
      cur.win  = fv && H_visible && V_visible && xe >= 160 && xe < 1120 && y >= 80 && y < 944;
      cur.idx  = ((y - 80) / 6) * 160 + (xe - 160) / 6;
      cur.bank = bankm;
      take     = vprev_f && !V_visible && (pend || fb_swap_req);
      exp_ack  = take;
      if (take) bankm = ~bankm;
      pend     = take ? 1'b0 : (pend | fb_swap_req);
      vprev_r  = V_visible;
      vprev_f  = V_visible;
      h3 = h2; h2 = h1; h1 = cur;
    end
  end

  task automatic line(input int y, input int xs, input int xend, input int req_x);
    for (int x = xs; x < xend; x++) begin
      @(posedge pixel_clk); #1;
      X_pix = 11'(x); Y_pix = 11'(y); H_visible = 1'b1; fb_swap_req = (x == req_x);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge pixel_clk); #1;
      H_visible = 1'b0; fb_swap_req = 1'b0;
    end
  endtask

  // Most lines are short runs that start before the image edge. Only rows that
  // feed the vector table are scanned across the full width.
  task automatic frame(input int y0, input int y1, input bit big, input int r1, input int r2);
    int xs, len;
    @(posedge pixel_clk); #1;
    V_visible = 1'b1; H_visible = 1'b0;
    for (int y = y0; y <= y1; y++) begin
      if (big && slot_of(y) >= 0) begin
        line(y, 0, 1280, (y == r1 || y == r2) ? 640 : -1);
      end else begin
        xs  = $urandom_range(140, 157);
        len = $urandom_range(8, 40);
        line(y, xs, xs + len, (y == r1 || y == r2) ? xs + 2 : -1);
      end
    end
  endtask

  int bank_i = 0;
  task automatic blank(input bit req_fall, input bit pending);
    int a0;
    int exp1;
    @(negedge pixel_clk);
    check("bank_before_fall", int'(fb_bank), bank_i);
    exp1 = (req_fall || pending) ? 1 : 0;
    if (exp1 == 1) bank_i = 1 - bank_i;
    a0 = ack_cnt;
    @(posedge pixel_clk); #1;
    H_visible = 1'b0; V_visible = 1'b0; fb_swap_req = req_fall;
    @(negedge pixel_clk);
    check("ack_at_fall", int'(fb_swap_ack), 0);
    @(posedge pixel_clk); #1;
    fb_swap_req = 1'b0;
    @(negedge pixel_clk);
    check("ack_after_fall", int'(fb_swap_ack), exp1);
    check("bank_after_fall", int'(fb_bank), bank_i);
    repeat (8) begin @(posedge pixel_clk); #1; end
    @(negedge pixel_clk);
    check("acks_per_blank", ack_cnt - a0, exp1);
  endtask

  typedef struct {
    int slot; int x; logic [11:0] col; bit chk_col; bit rd; bit chk_addr; int addr;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   r;
    bit   f;
    tbl.push_back('{1,  157, BORDER, 1, 0, 0, 0});
    tbl.push_back('{1,  159, BORDER, 1, 1, 1, 0});
    tbl.push_back('{1,  160, PAL0,   1, 1, 0, 0});
    tbl.push_back('{1,  165, PAL0,   1, 1, 0, 0});
    tbl.push_back('{1,  166, PAL1,   1, 1, 0, 0});
    tbl.push_back('{1,  171, PAL1,   1, 1, 0, 0});
    tbl.push_back('{1,  172, PAL2,   1, 1, 0, 0});
    tbl.push_back('{1,  178, PAL3,   1, 1, 0, 0});
    tbl.push_back('{1, 1117, PAL3,   1, 1, 1, 159});
    tbl.push_back('{1, 1118, PAL3,   1, 0, 0, 0});
    tbl.push_back('{1, 1119, PAL3,   1, 0, 0, 0});
    tbl.push_back('{1, 1120, BORDER, 1, 0, 0, 0});
    tbl.push_back('{0,  160, BORDER, 1, 0, 0, 0});
    tbl.push_back('{0,  600, BORDER, 1, 0, 0, 0});
    tbl.push_back('{5,  600, BORDER, 1, 0, 0, 0});
    tbl.push_back('{5, 1000, BORDER, 1, 0, 0, 0});
    tbl.push_back('{2,  159, BORDER, 0, 1, 1, 0});
    tbl.push_back('{2, 1117, BORDER, 0, 1, 1, 159});
    tbl.push_back('{3,  159, BORDER, 0, 1, 1, 160});
    tbl.push_back('{3, 1117, BORDER, 0, 1, 1, 319});
    tbl.push_back('{4,  159, BORDER, 0, 1, 1, 22880});
    tbl.push_back('{4, 1117, BORDER, 0, 1, 1, 23039});

    rst = 1'b1; X_pix = 11'd500; Y_pix = 11'd300;
    H_visible = 1'b1; V_visible = 1'b1; fb_swap_req = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 2'($urandom);
    for (int k = 0; k < 160; k++) mem[k] = 2'(k % 4);

    // Reset released in the middle of a visible line.
    repeat (4) @(posedge pixel_clk);
    #1 rst = 1'b0;
    line(300, 501, 700, -1);
    line(301, 140, 170, -1);
    blank(1'b0, 1'b0);

    // A full frame carrying one mid-frame request, followed by the table checks.
    cap_en = 1'b1;
    frame(79, 944, 1'b1, 300, -1);
    cap_en = 1'b0;
    blank(1'b0, 1'b1);
    foreach (tbl[i]) begin
      if (tbl[i].chk_col)
        check($sformatf("tbl%0d_color", i), int'(cap_col[tbl[i].slot][tbl[i].x]), int'(tbl[i].col));
      check($sformatf("tbl%0d_rd_en", i), int'(cap_rd[tbl[i].slot][tbl[i].x]), int'(tbl[i].rd));
      if (tbl[i].chk_addr)
        check($sformatf("tbl%0d_addr", i), int'(cap_addr[tbl[i].slot][tbl[i].x]), tbl[i].addr);
    end

    // Three requests, one of them on the blanking edge: exactly one swap.
    frame(78, 90, 1'b0, 82, 88);
    blank(1'b1, 1'b1);
    // A request that arrives only on the edge is still taken.
    frame(78, 90, 1'b0, -1, -1);
    blank(1'b1, 1'b0);
    // No request: the bank holds.
    frame(78, 90, 1'b0, -1, -1);
    blank(1'b0, 1'b0);

    // Random frame contents and random requests.
    repeat (3) begin
      for (int i = 0; i < 65536; i++) mem[i] = 2'($urandom);
      r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(76, 100)) : -1;
      f = 1'($urandom_range(0, 1));
      frame(76, 100, 1'b0, r, -1);
      blank(f, r >= 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gb_frame_scaler.md
# gb_frame_scaler

Pixel source for the 1280x1024@60 VGA timing stage. Converts the stage's scan coordinates into reads of a double-banked 160x144 Game Boy frame buffer (2-bit shades), integer-upscales by SCALE, maps shades through a 4-entry palette and drives the 12-bit `pixel_color` bus the timing stage latches. Runs entirely on `pixel_clk`. Owns the frame-buffer bank swap handshake with the Game Boy LCD capture logic.

## Interface
- SCALE, 6: integer upscale factor, 960x864 active image.
- H_OFFSET, 160: first screen column of the image.
- V_OFFSET, 80: first screen row of the image.
- LEAD, 3: pipeline depth compensated internally.
- PAL0..PAL3, 12'hBF9 / 12'h7A5 / 12'h353 / 12'h120: 12-bit colour per shade, {B,G,R} nibbles.
- BORDER, 12'h000: colour outside the image window.

Ports:
- pixel_clk  in  1  pixel clock, sole clock.
- rst  in  1  asynchronous, active-high reset.
- X_pix  in  11  current visible column from the timing stage.
- Y_pix  in  11  current visible row.
- H_visible  in  1  horizontal active flag.
- V_visible  in  1  vertical active flag.
- fb_addr  out  16  {bank, row*160+col}, to synchronous frame RAM.
- fb_rd_en  out  1  RAM read enable.
- fb_data  in  2  RAM read data, valid 1 cycle after address.
- fb_swap_req  in  1  one-cycle pulse: capture side finished a frame.
- fb_swap_ack  out  1  one-cycle pulse: bank swapped.
- fb_bank  out  1  bank currently displayed; capture writes the other.
- pixel_color  out  12  colour for the current coordinate.

## Operation
- Effective column Xe = X_pix + LEAD (11-bit add, no wrap possible inside visible region). Image window: H_OFFSET <= Xe < H_OFFSET+160*SCALE and V_OFFSET <= Y_pix < V_OFFSET+144*SCALE, both with H_visible & V_visible high.
- Horizontal: sub-counter hs (0..SCALE-1) and column gc (0..159). Both clear when Xe == H_OFFSET; hs increments each cycle in window, wraps to 0 with gc+1. gc saturates at 159; no dividers.
- Vertical: sub-counter vs and row gr (0..143). Cleared while V_visible low. On each H_visible falling edge with Y_pix inside the window, vs increments, wraps at SCALE with gr+1 (saturate at 143). Row index = gr*160, held in a registered row base updated by +160 on gr increment (no multiplier).
- Stage 0: fb_addr <= {fb_bank, rowbase+gc}; fb_rd_en <= in-window; window flag pipelined.
- Stage 1: RAM returns fb_data.
- Stage 2: pixel_color <= window flag ? PALn[fb_data] : BORDER; outside H_visible & V_visible it is 12'h000.
- Swap handshake: fb_swap_req sets a pending flag. Swap happens on V_visible falling edge (start of vertical blank): fb_bank toggles, fb_swap_ack pulses one cycle, pending clears. Request arriving the same cycle as the falling edge is taken in that swap. Multiple requests before a blank collapse to one swap. Bank never changes during visible lines.

## Timing
- Reset values: fb_addr 0, fb_rd_en 0, fb_swap_ack 0, fb_bank 0, pixel_color 12'h000, all counters and pending 0.
- Latency coordinate -> pixel_color: exactly LEAD (3) cycles, compensated so pixel_color during X_pix = n is the colour of screen column n.
- fb_addr changes every SCALE cycles within a line; fb_rd_en high only in window.
- fb_swap_ack high exactly one cycle, coincident with fb_bank toggle, 1 cycle after V_visible falls.
- Reset mid-frame: all state cleared immediately; first full image starts after the next V_visible rising edge.

## Test plan
- Reset held, then released mid-line -> all outputs 0; fb_bank 0; no ack until first vertical blank with pending request.
- Scan line Y_pix=80, fb_data column k = k%4 -> pixel_color BORDER for X_pix<160, PAL0 at X_pix 160..165, PAL1 at 166..171, BORDER from 1120.
- Full frame -> fb_addr row base 0 for Y_pix 80..85, 160 for 86..91, last row 22880 at Y_pix 938..943; fb_addr max 22879+1? no: max index 23039.
- fb_swap_req pulse mid-frame -> fb_bank unchanged until V_visible falls, then toggles with one-cycle fb_swap_ack; addresses carry new bank bit next frame.
- Three swap_req pulses in one frame, one coincident with V_visible fall -> exactly one toggle, one ack.
- Y_pix 79 and 944 lines -> pixel_color BORDER across all visible columns, fb_rd_en 0.
